jtframe_lfbuf_scan: RTL



---
 rtl/jtframe_lfbuf_scan_pkg.sv | 10 +
 rtl/jtframe_dual_ram.sv | 22 ++
 rtl/jtframe_lfbuf_scan.sv | 83 ++++++++
 3 files changed

// File: rtl/jtframe_lfbuf_scan_pkg.sv
// Shared types for the line-frame-buffer scan-out stage.
package jtframe_lfbuf_scan_pkg;

   typedef enum logic { BANK_A = 1'b0, BANK_B = 1'b1 } bank_e;

   function automatic bank_e other_bank(bank_e b);
      return (b == BANK_A) ? BANK_B : BANK_A;
   endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with a registered output.
module jtframe_dual_ram #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we0_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [DW-1:0] data0_i,
   input  logic [AW-1:0] addr1_i,
   output logic [DW-1:0] q1_o
);

   logic [DW-1:0] mem_q [0:(2**AW)-1];

   // Contents are deliberately not reset; ports never target the same bank.
   always_ff @(posedge clk) begin
      if (we0_i) mem_q[addr0_i] <= data0_i;
      q1_o <= mem_q[addr1_i];
   end

endmodule

// File: rtl/jtframe_lfbuf_scan.sv
// Ping-pong line buffer scan-out: fills one bank during H blank, plays the other
// bank at pxl_cen, and flags lines that arrived incomplete at the swap point.
module jtframe_lfbuf_scan
   import jtframe_lfbuf_scan_pkg::*;
#(
   parameter int            HW     = 9,
   parameter int            DW     = 16,
   parameter logic [DW-1:0] BLANK  = '0,
   parameter bit            REPEAT = 1'b1
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          pxl_cen,
   input  logic          lhbl,
   input  logic          lvbl,
   input  logic [HW-1:0] hdump,
   input  logic [HW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic          wr_en,
   output logic [DW-1:0] pxl,
   output logic          short_ln,
   output logic          bank
);

   localparam logic [HW:0] FULL = {1'b1, {HW{1'b0}}};

   logic          lhbl_l_q, lhbl_l_d;
   logic [HW:0]   fill_q,   fill_d;
   bank_e         wbank_q,  wbank_d;
   logic          short_q,  short_d;
   logic [DW-1:0] pxl_q,    pxl_d;
   logic [DW-1:0] rd_q;
   logic          swap, complete;

   jtframe_dual_ram #(.AW(HW+1), .DW(DW)) u_ram (
      .clk     ( clk                          ),
      .we0_i   ( wr_en                        ),
      .addr0_i ( {wbank_q, wr_addr}           ),
      .data0_i ( wr_data[DW-1:0]              ),
      .addr1_i ( {other_bank(wbank_q), hdump} ),
      .q1_o    ( rd_q                         )
   );

   always_comb begin
      swap      = pxl_cen & lhbl & ~lhbl_l_q;
      complete  = (fill_q == FULL);
      lhbl_l_d  = pxl_cen ? lhbl : lhbl_l_q;
      fill_d    = fill_q;
      wbank_d   = wbank_q;
      short_d   = 1'b0;
      pxl_d     = pxl_q;
      // A write on the swap clk still lands in the old bank but is not counted.
      if (swap) begin
         fill_d  = '0;
         short_d = ~complete;
         if (complete || !REPEAT) wbank_d = other_bank(wbank_q);
      end else if (wr_en && !complete) begin
         fill_d = fill_q + 1'b1;
      end
      if (pxl_cen) pxl_d = (lhbl & lvbl) ? rd_q : BLANK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lhbl_l_q <= 1'b0;
         fill_q   <= '0;
         wbank_q  <= BANK_A;
         short_q  <= 1'b0;
         pxl_q    <= BLANK;
      end else begin
         lhbl_l_q <= lhbl_l_d;
         fill_q   <= fill_d;
         wbank_q  <= wbank_d;
         short_q  <= short_d;
         pxl_q    <= pxl_d;
      end
   end

   assign pxl      = pxl_q;
   assign short_ln = short_q;
   assign bank     = wbank_q;

endmodule
